// File: rtl/rename_unit.sv
// rename_unit: single-wide register-rename pipeline stage.
// A circular free-list FIFO supplies new physical tags. A speculative RAT
// maps source and destination registers at rename time, and a retirement RAT
// tracks the committed mapping. A flush copies the retirement RAT into the
// speculative RAT and rewinds the allocation pointer in a single cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid / in_ready          decode handshake
//   in_rd, in_rs1, in_rs2        architectural register indices
//   in_reg_write                 instruction writes rd
//   out_valid / out_ready        downstream handshake (registered output)
//   out_prd, out_prs1, out_prs2  renamed tags
//   out_old_prd                  previous mapping of rd, freed at commit
//   commit_*                     in-order retirement of one instruction
//   flush                        mispredict/exception recovery
//   free_count                   entries currently in the free list
//   overflow_err                 sticky; a commit pushed into a full free list
//
// The free-list pointers use a wrap bit, so FL_DEPTH must be a power of two.
module rename_unit #(
  parameter int NUM_AREG   = 32,
  parameter int NUM_PREG   = 64,
  parameter int AREG_WIDTH = $clog2(NUM_AREG),
  parameter int PREG_WIDTH = $clog2(NUM_PREG),
  parameter int FL_DEPTH   = NUM_PREG - NUM_AREG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AREG_WIDTH-1:0]     in_rd,
  input  logic [AREG_WIDTH-1:0]     in_rs1,
  input  logic [AREG_WIDTH-1:0]     in_rs2,
  input  logic                      in_reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PREG_WIDTH-1:0]     out_prd,
  output logic [PREG_WIDTH-1:0]     out_prs1,
  output logic [PREG_WIDTH-1:0]     out_prs2,
  output logic [PREG_WIDTH-1:0]     out_old_prd,
  input  logic                      commit_valid,
  input  logic                      commit_reg_write,
  input  logic [AREG_WIDTH-1:0]     commit_rd,
  input  logic [PREG_WIDTH-1:0]     commit_prd,
  input  logic [PREG_WIDTH-1:0]     commit_old_prd,
  input  logic                      flush,
  output logic [$clog2(FL_DEPTH):0] free_count,
  output logic                      overflow_err
);

  localparam int IW = $clog2(FL_DEPTH);
  localparam int PW = IW + 1;

  logic [PREG_WIDTH-1:0] fifo     [FL_DEPTH];
  logic [PREG_WIDTH-1:0] spec_rat [NUM_AREG];
  logic [PREG_WIDTH-1:0] ret_rat  [NUM_AREG];

  logic [PW-1:0] head, tail, commit_head, commit_head_nxt;
  logic          alloc, accept, push, fl_full, push_ok;

  assign free_count = tail - head;
  assign alloc      = in_reg_write && (in_rd != '0);
  assign in_ready   = !flush && (!out_valid || out_ready) && (!alloc || free_count != '0);
  assign accept     = in_valid && in_ready;

  // Commits to x0 never allocated a tag, so they are dropped entirely.
  assign push       = commit_valid && commit_reg_write && (commit_rd != '0);
  assign fl_full    = (free_count == PW'(FL_DEPTH));
  assign push_ok    = push && !fl_full;

  // A rejected push leaves both tail and commit_head alone so that a later
  // flush cannot rewind head past tail.
  assign commit_head_nxt = push_ok ? commit_head + PW'(1) : commit_head;

  // Free list storage and both RATs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) fifo[i] <= PREG_WIDTH'(NUM_AREG + i);
      for (int a = 0; a < NUM_AREG; a++) begin
        spec_rat[a] <= PREG_WIDTH'(a);
        ret_rat[a]  <= PREG_WIDTH'(a);
      end
    end else begin
      if (push_ok) fifo[tail[IW-1:0]] <= commit_old_prd;
      if (push) ret_rat[commit_rd] <= commit_prd;
      if (flush) begin
        // Restore from the retirement RAT including this cycle's commit.
        for (int a = 0; a < NUM_AREG; a++)
          spec_rat[a] <= (push && commit_rd == AREG_WIDTH'(a)) ? commit_prd : ret_rat[a];
      end else if (accept && alloc) begin
        spec_rat[in_rd] <= fifo[head[IW-1:0]];
      end
    end
  end

  // Pointers, output register and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      commit_head  <= '0;
      tail         <= PW'(FL_DEPTH);
      out_valid    <= 1'b0;
      out_prd      <= '0;
      out_prs1     <= '0;
      out_prs2     <= '0;
      out_old_prd  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      commit_head <= commit_head_nxt;
      if (push && fl_full) overflow_err <= 1'b1;

      if (flush) head <= commit_head_nxt;
      else if (accept && alloc) head <= head + PW'(1);

      if (accept) begin
        out_valid   <= 1'b1;
        out_prs1    <= spec_rat[in_rs1];
        out_prs2    <= spec_rat[in_rs2];
        out_prd     <= alloc ? fifo[head[IW-1:0]] : '0;
        out_old_prd <= alloc ? spec_rat[in_rd] : '0;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed vectors with hand-computed expectations for
// rename_unit at the default parameters (32 areg, 64 preg, 32-entry free list).
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_reg_write;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic       out_valid, out_ready;
  logic [5:0] out_prd, out_prs1, out_prs2, out_old_prd;
  logic       commit_valid, commit_reg_write;
  logic [4:0] commit_rd;
  logic [5:0] commit_prd, commit_old_prd;
  logic       flush;
  logic [5:0] free_count;
  logic       overflow_err;

  int total = 0;
  int bad   = 0;

  rename_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prd(out_prd), .out_prs1(out_prs1), .out_prs2(out_prs2), .out_old_prd(out_old_prd),
    .commit_valid(commit_valid), .commit_reg_write(commit_reg_write),
    .commit_rd(commit_rd), .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .flush(flush), .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid     = v;
    in_reg_write = we;
    in_rd        = rd;
    in_rs1       = rs1;
    in_rs2       = rs2;
  endtask

  task automatic commit(input logic v, input logic [4:0] rd,
                        input logic [5:0] prd, input logic [5:0] old);
    commit_valid     = v;
    commit_reg_write = v;
    commit_rd        = rd;
    commit_prd       = prd;
    commit_old_prd   = old;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    commit(0, 0, 0, 0);
    out_ready = 1'b1;
    flush     = 1'b0;
    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_prd", out_prd, 0);
    chk("rst_free_count", free_count, 32);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // x1, x2, x1 back to back
    drive(1, 1, 1, 0, 0); tick();
    chk("a1_valid", out_valid, 1);
    chk("a1_prd", out_prd, 32);
    chk("a1_old", out_old_prd, 1);
    drive(1, 1, 2, 1, 0); tick();
    chk("a2_prd", out_prd, 33);
    chk("a2_prs1", out_prs1, 32);
    chk("a2_old", out_old_prd, 2);
    drive(1, 1, 1, 2, 1); tick();
    chk("a3_prd", out_prd, 34);
    chk("a3_old", out_old_prd, 32);
    chk("a3_prs1", out_prs1, 33);
    chk("a3_prs2", out_prs2, 32);
    chk("a3_free", free_count, 29);

    // rd = x0 with reg_write: no allocation
    drive(1, 1, 0, 0, 0); tick();
    chk("x0_prd", out_prd, 0);
    chk("x0_old", out_old_prd, 0);
    chk("x0_prs1", out_prs1, 0);
    chk("x0_free", free_count, 29);

    // non-writing instruction reading x1
    drive(1, 0, 3, 1, 0); tick();
    chk("nw_prd", out_prd, 0);
    chk("nw_prs1", out_prs1, 34);
    chk("nw_free", free_count, 29);

    // stall: output held for 5 cycles
    out_ready = 1'b0;
    drive(1, 1, 4, 2, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_prs1", out_prs1, 34);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_prd", out_prd, 35);
    chk("release_old", out_old_prd, 4);
    chk("release_prs1", out_prs1, 33);
    chk("release_free", free_count, 28);

    // drain the free list
    for (int i = 0; i < 28; i++) begin
      drive(1, 1, 5'(8 + (i % 4)), 0, 0);
      tick();
      chk("fill_prd", out_prd, 36 + i);
    end
    chk("empty_free", free_count, 0);
    drive(1, 1, 12, 0, 0);
    #1;
    chk("empty_in_ready_w", in_ready, 0);
    drive(1, 0, 12, 1, 0);
    #1;
    chk("empty_in_ready_nw", in_ready, 1);
    tick();
    chk("empty_nw_prd", out_prd, 0);
    chk("empty_nw_prs1", out_prs1, 34);
    chk("empty_nw_valid", out_valid, 1);

    // asynchronous reset mid-operation
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_free", free_count, 32);
    tick();
    rst = 1'b0;

    // allocate x5, x6; commit x5; flush
    drive(1, 1, 5, 0, 0); tick();
    chk("fl_a5_prd", out_prd, 32);
    drive(1, 1, 6, 0, 0); tick();
    chk("fl_a6_prd", out_prd, 33);
    drive(0, 0, 0, 0, 0);
    commit(1, 5, 32, 5); tick();
    commit(0, 0, 0, 0);
    chk("fl_commit_free", free_count, 31);
    flush = 1'b1;
    drive(1, 1, 7, 0, 0);
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_free", free_count, 32);
    drive(1, 1, 7, 5, 6); tick();
    chk("fl_next_prd", out_prd, 33);
    chk("fl_spec5", out_prs1, 32);
    chk("fl_spec6", out_prs2, 6);
    chk("fl_next_old", out_old_prd, 7);
    drive(0, 0, 0, 0, 0); tick();
    chk("drain_valid", out_valid, 0);

    // overflow: push into a full free list
    do_reset();
    commit(1, 3, 3, 3); tick();
    commit(0, 0, 0, 0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_free", free_count, 32);
    tick(); tick();
    chk("ovf_sticky", overflow_err, 1);
    do_reset();
    chk("ovf_clear", overflow_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
# rename_unit

Parametrised register-rename stage for the out-of-order core. It replaces the single-shot rename with a valid/ready-handshaked rename pipeline stage. The stage uses a circular free-list FIFO, a speculative RAT and a retirement RAT, and frees physical registers in-order at commit. A flush restores both the speculative mapping and the free list in one cycle. It sits between decode and the reservation station / ROB allocation.

## Interface
Parameters:
- NUM_AREG, 32: architectural registers; x0 is hard-wired and never renamed.
- NUM_PREG, 64: physical registers; must exceed NUM_AREG.
- AREG_WIDTH, 5: $clog2(NUM_AREG).
- PREG_WIDTH, 6: $clog2(NUM_PREG).
- FL_DEPTH, NUM_PREG-NUM_AREG: free-list entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_rd, in_rs1, in_rs2  in  AREG_WIDTH each  architectural indices.
- in_reg_write  in  1  instruction writes rd.
- out_valid  out  1  renamed instruction held in the output register.
- out_ready  in  1  downstream consumes the output.
- out_prd, out_prs1, out_prs2, out_old_prd  out  PREG_WIDTH each  renamed tags.
- commit_valid  in  1  ROB retires one instruction.
- commit_reg_write  in  1  the retiring instruction allocated a register.
- commit_rd  in  AREG_WIDTH  architectural destination of the retiring instruction.
- commit_prd  in  PREG_WIDTH  physical destination of the retiring instruction.
- commit_old_prd  in  PREG_WIDTH  tag to free.
- flush  in  1  mispredict/exception recovery.
- free_count  out  $clog2(FL_DEPTH)+1  entries currently in the free list.
- overflow_err  out  1  sticky; set on a push into a full free list.

## Operation
- **Free list**
  - Circular FIFO with head (alloc), tail (free) and commit_head pointers, each $clog2(FL_DEPTH)+1 bits with a wrap bit.
  - free_count = tail - head.
- **Reset**
  - FIFO entry i = NUM_AREG+i; head = commit_head = 0; tail = FL_DEPTH.
  - Both RATs map a -> a.
  - out_valid=0; all out_* tags=0; overflow_err=0; free_count=FL_DEPTH.
- **Allocation condition:** alloc = in_reg_write && in_rd != 0.
- **in_ready** = !flush && (!out_valid || out_ready) && (!alloc || free_count != 0).
  - in_ready is combinational from in_rd/in_reg_write.
- **Accept** (in_valid && in_ready):
  - Output register loads out_prs1 = specRAT[in_rs1], out_prs2 = specRAT[in_rs2] and out_old_prd = specRAT[in_rd].
  - If alloc: out_prd = fifo[head]; head++; specRAT[in_rd] = out_prd.
  - If not alloc: out_prd = 0 and out_old_prd = 0.
  - out_valid is set to 1.
- **No accept:** out_valid clears when out_ready=1; the output holds otherwise (stall).
- **Commit** (commit_valid && commit_reg_write):
  - fifo[tail] = commit_old_prd; tail++; commit_head++; retRAT[commit_rd] = commit_prd.
  - A commit with commit_rd = 0 is ignored.
  - A push when free_count == FL_DEPTH sets overflow_err; tail is not advanced.
- **Flush:**
  - specRAT := retRAT (after applying any same-cycle commit); head := commit_head (after same-cycle increment).
  - out_valid := 0; in_valid is ignored.
  - Speculatively allocated tags return to the free list implicitly.
- **Same-cycle events:**
  - Allocate + commit: both pointer updates apply.
  - A commit push does not bypass to an allocation in the same cycle (empty stays stalled one cycle).
- **Back-to-back accepts:** rs1 of the next instruction sees a RAT updated at the accepting edge; there is no intra-cycle bypass because the stage is single-wide.

## Timing
- Rename latency is 1 cycle: accept at edge N -> out_* valid after edge N.
- Throughput is 1 instruction/cycle while out_ready=1 and the free list is non-empty.
- Commit-to-free visibility: a tag pushed at edge N is allocatable from edge N+1.
- Flush takes effect at the next edge. in_ready is 0 during the flush cycle; the stage is normal from the following cycle.
- rst asserted mid-operation returns all state to reset values immediately; pending output is discarded.

## Test plan
- Reset, then 3 accepts writing x1, x2, x1 with out_ready=1 -> out_prd = 32, 33, 34; the third has out_old_prd=32; free_count=29.
- Instruction with in_rd=0, in_reg_write=1 -> out_prd=0, no pop; free_count unchanged; RAT[0] stays 0.
- 32 allocations without commit -> free_count=0; a 33rd writing instruction sees in_ready=0. A non-writing instruction is still accepted.
- Hold out_ready=0 with out_valid=1 -> in_ready=0 and out_* stable for 5 cycles; release -> next accept the following edge.
- Allocate x5->32 and x6->33, commit x5 (old_prd=5), then flush -> specRAT[5]=32, specRAT[6]=6; head=commit_head=1; free_count=32; next allocation returns 33.
- Commit push with free_count=FL_DEPTH -> overflow_err=1 sticky until rst; tail unchanged.
